// File: rtl/pdcch_out_serializer_if.sv
// Stream interface for the PDCCH output serializer: word input side (s_ser_*)
// and beat output side (m_ser_*).
interface pdcch_out_serializer_if #(
  parameter int WORD_WIDTH     = 64,
  parameter int DATA_OUT_WIDTH = 8
);
   logic                      s_ser_valid;
   logic                      s_ser_ready;
   logic [WORD_WIDTH-1:0]     s_ser_data;
   logic                      m_ser_valid;
   logic                      m_ser_ready;
   logic [DATA_OUT_WIDTH-1:0] m_ser_data;
   logic                      m_ser_last;

   // serializer side
   modport slave (
      input  s_ser_valid, s_ser_data, m_ser_ready,
      output s_ser_ready, m_ser_valid, m_ser_data, m_ser_last
   );

   // producer/consumer side
   modport master (
      output s_ser_valid, s_ser_data, m_ser_ready,
      input  s_ser_ready, m_ser_valid, m_ser_data, m_ser_last
   );
endinterface

// File: rtl/pdcch_out_serializer.sv
// Splits WORD_WIDTH words into DATA_OUT_WIDTH beats, LS beat first, no bubble between words.
// Define PDCCH_SER_CHECKSUM_EN to append an XOR-of-beats checksum beat to each word.
module pdcch_out_serializer #(
   parameter int WORD_WIDTH     = 64,
   parameter int DATA_OUT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   pdcch_out_serializer_if.slave ser,
   output logic [15:0]           word_count
);
   localparam int NBEATS = WORD_WIDTH / DATA_OUT_WIDTH;
   localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   generate
      if ((WORD_WIDTH % DATA_OUT_WIDTH) != 0 || NBEATS < 2) begin : g_bad_cfg
         $error("WORD_WIDTH must be a multiple of DATA_OUT_WIDTH with at least 2 beats");
      end
   endgenerate

`ifdef PDCCH_SER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t                    state, state_nxt;
   logic [WORD_WIDTH-1:0]     hold;
   logic [IDX_W-1:0]          idx;
   logic                      run;        // low until the first edge after reset release
   logic                      xfer, final_beat, load, last_data;
   logic [DATA_OUT_WIDTH-1:0] data_beat;

   assign last_data  = (idx == LAST_IDX);
   assign data_beat  = hold[idx*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
   assign xfer       = ser.m_ser_valid & ser.m_ser_ready;

`ifdef PDCCH_SER_CHECKSUM_EN
   logic [DATA_OUT_WIDTH-1:0] csum;
   always_comb begin
      csum = '0;
      for (int i = 0; i < NBEATS; i++)
         csum = csum ^ hold[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
   end
   assign final_beat     = (state == CHK);
   assign ser.m_ser_valid = (state == SEND) || (state == CHK);
   assign ser.m_ser_data  = (state == CHK) ? csum : data_beat;
`else
   assign final_beat     = (state == SEND) && last_data;
   assign ser.m_ser_valid = (state == SEND);
   assign ser.m_ser_data  = data_beat;
`endif

   assign ser.m_ser_last  = final_beat;
   // Ready again during the final transfer so the next word loads without a bubble.
   assign ser.s_ser_ready = run & ((state == IDLE) | (final_beat & ser.m_ser_ready));
   assign load            = ser.s_ser_valid & ser.s_ser_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load) state_nxt = SEND;
         SEND: begin
            if (xfer && last_data) begin
`ifdef PDCCH_SER_CHECKSUM_EN
               state_nxt = CHK;
`else
               state_nxt = load ? SEND : IDLE;
`endif
            end
         end
`ifdef PDCCH_SER_CHECKSUM_EN
         CHK: if (xfer) state_nxt = load ? SEND : IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run        <= 1'b0;
         hold       <= '0;
         idx        <= '0;
         word_count <= '0;
      end else begin
         run <= 1'b1;
         if (load) begin
            hold <= ser.s_ser_data;
            idx  <= '0;
         end else if (xfer && state == SEND) begin
            idx <= last_data ? '0 : idx + 1'b1;
         end
         if (xfer && final_beat) word_count <= word_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_pdcch_out_serializer.sv
// Directed bench for pdcch_out_serializer at WORD_WIDTH=32, DATA_OUT_WIDTH=8.
module tb_pdcch_out_serializer;
   localparam int WW = 32;
   localparam int DW = 8;
`ifdef PDCCH_SER_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] word_count;
   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_wc = 0;

   pdcch_out_serializer_if #(.WORD_WIDTH(WW), .DATA_OUT_WIDTH(DW)) sif ();

   pdcch_out_serializer #(.WORD_WIDTH(WW), .DATA_OUT_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .ser        (sif.slave),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // beat i of word w; index 4 is the checksum beat
   function automatic logic [7:0] exp_beat(input logic [31:0] w, input int i);
      if (i < 4) return w[i*8 +: 8];
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      sif.s_ser_valid = 1'b0;
      sif.s_ser_data  = '0;
      sif.m_ser_ready = 1'b1;
      repeat (3) tick();
      #1;
      n_cmp++;
      if ({sif.m_ser_valid, sif.m_ser_last, sif.s_ser_ready, sif.m_ser_data, word_count} !== 27'd0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b l=%b rdy=%b d=%h wc=%h want all zero",
                  sif.m_ser_valid, sif.m_ser_last, sif.s_ser_ready, sif.m_ser_data, word_count);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (sif.s_ser_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ready_before_edge: got %b want 0", sif.s_ser_ready);
      end
      tick();
      n_cmp++;
      if ({sif.s_ser_ready, sif.m_ser_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL ready_after_release: got rdy=%b v=%b want rdy=1 v=0", sif.s_ser_ready, sif.m_ser_valid);
      end
      exp_wc = 0;
   endtask

   task automatic test_single(input logic [31:0] w);
      sif.s_ser_valid = 1'b1;
      sif.s_ser_data  = w;
      sif.m_ser_ready = 1'b1;
      #1;
      n_cmp++;
      if ({sif.s_ser_ready, sif.m_ser_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL single_idle: got rdy=%b v=%b want rdy=1 v=0", sif.s_ser_ready, sif.m_ser_valid);
      end
      for (int i = 0; i < NB; i++) begin
         tick();
         sif.s_ser_valid = 1'b0;
         #1;
         n_cmp++;
         if ({sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data, sif.s_ser_ready} !==
             {1'b1, i == NB-1, exp_beat(w, i), i == NB-1}) begin
            n_err++;
            $display("FAIL single_beat%0d: got v=%b l=%b d=%h rdy=%b want v=1 l=%b d=%h rdy=%b", i,
                     sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data, sif.s_ser_ready,
                     i == NB-1, exp_beat(w, i), i == NB-1);
         end
      end
      tick();
      exp_wc++;
      n_cmp++;
      if ({sif.m_ser_valid, word_count} !== {1'b0, 16'(exp_wc)}) begin
         n_err++;
         $display("FAIL single_end: got v=%b wc=%0d want v=0 wc=%0d", sif.m_ser_valid, word_count, exp_wc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [2];
      w[0] = 32'h11223344;
      w[1] = 32'h55667788;
      sif.m_ser_ready = 1'b1;
      sif.s_ser_valid = 1'b1;
      sif.s_ser_data  = w[0];
      for (int i = 0; i < 2*NB; i++) begin
         tick();
         sif.s_ser_data  = w[1];
         sif.s_ser_valid = (i < NB);
         #1;
         n_cmp++;
         if ({sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data} !==
             {1'b1, (i % NB) == NB-1, exp_beat(w[i/NB], i % NB)}) begin
            n_err++;
            $display("FAIL b2b_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i,
                     sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data,
                     (i % NB) == NB-1, exp_beat(w[i/NB], i % NB));
         end
      end
      tick();
      exp_wc += 2;
      n_cmp++;
      if ({sif.m_ser_valid, word_count} !== {1'b0, 16'(exp_wc)}) begin
         n_err++;
         $display("FAIL b2b_end: got v=%b wc=%0d want v=0 wc=%0d", sif.m_ser_valid, word_count, exp_wc);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      w = 32'hA1B2C3D4;
      sif.m_ser_ready = 1'b1;
      sif.s_ser_valid = 1'b1;
      sif.s_ser_data  = w;
      tick();
      sif.s_ser_valid = 1'b0;
      #1;
      n_cmp++;
      if ({sif.m_ser_valid, sif.m_ser_data} !== {1'b1, 8'hD4}) begin
         n_err++;
         $display("FAIL bp_first: got v=%b d=%h want v=1 d=d4", sif.m_ser_valid, sif.m_ser_data);
      end
      tick();
      // stall on C3 while offering a word that must be ignored
      sif.m_ser_ready = 1'b0;
      sif.s_ser_valid = 1'b1;
      sif.s_ser_data  = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if ({sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data, sif.s_ser_ready} !== {2'b10, 8'hC3, 1'b0}) begin
            n_err++;
            $display("FAIL bp_hold%0d: got v=%b l=%b d=%h rdy=%b want v=1 l=0 d=c3 rdy=0", c,
                     sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data, sif.s_ser_ready);
         end
         tick();
      end
      sif.s_ser_valid = 1'b0;
      sif.m_ser_ready = 1'b1;
      for (int i = 1; i < NB; i++) begin
         #1;
         n_cmp++;
         if ({sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data} !== {1'b1, i == NB-1, exp_beat(w, i)}) begin
            n_err++;
            $display("FAIL bp_resume%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i,
                     sif.m_ser_valid, sif.m_ser_last, sif.m_ser_data, i == NB-1, exp_beat(w, i));
         end
         tick();
      end
      exp_wc++;
      n_cmp++;
      if ({sif.m_ser_valid, word_count} !== {1'b0, 16'(exp_wc)}) begin
         n_err++;
         $display("FAIL bp_end: got v=%b wc=%0d want v=0 wc=%0d", sif.m_ser_valid, word_count, exp_wc);
      end
   endtask

   task automatic test_reset_mid_word();
      sif.m_ser_ready = 1'b1;
      sif.s_ser_valid = 1'b1;
      sif.s_ser_data  = 32'hA1B2C3D4;
      tick();                // D4 on the bus
      sif.s_ser_valid = 1'b0;
      tick();                // C3 on the bus
      tick();                // C3 transferred, B2 presented
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({sif.m_ser_valid, sif.m_ser_last, sif.s_ser_ready, sif.m_ser_data, word_count} !== 27'd0) begin
         n_err++;
         $display("FAIL midreset_async: got v=%b l=%b rdy=%b d=%h wc=%h want all zero",
                  sif.m_ser_valid, sif.m_ser_last, sif.s_ser_ready, sif.m_ser_data, word_count);
      end
      tick();
      reset = 1'b1;
      exp_wc = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({sif.m_ser_valid, sif.s_ser_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL midreset_idle%0d: got v=%b rdy=%b want v=0 rdy=1", c, sif.m_ser_valid, sif.s_ser_ready);
         end
      end
      test_single(32'h01020304);
   endtask

   initial begin
      sif.s_ser_valid = 1'b0;
      sif.s_ser_data  = '0;
      sif.m_ser_ready = 1'b0;
      test_reset();
      test_single(32'hA1B2C3D4);
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pdcch_out_serializer.md
PDCCH_OUT_SERIALIZER -- requirements
Module: pdcch_out_serializer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 64: width of one PDCCH output word accepted from the top-level output stream.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 8: width of one serialized output beat.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_ser_valid  input  1  input word valid.
REQ-006 SHALL have port s_ser_ready  output  1  serializer can accept a word.
REQ-007 SHALL have port s_ser_data  input  WORD_WIDTH  PDCCH output word.
REQ-008 SHALL have port m_ser_valid  output  1  output beat valid.
REQ-009 SHALL have port m_ser_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port m_ser_data  output  DATA_OUT_WIDTH  output beat.
REQ-011 SHALL have port m_ser_last  output  1  marks the final beat of a word.
REQ-012 SHALL have port word_count  output  16  count of fully transmitted words, wraps 0xFFFF->0x0000.

Function
REQ-013 SHALL require WORD_WIDTH to be an integer multiple of DATA_OUT_WIDTH, with NBEATS = WORD_WIDTH/DATA_OUT_WIDTH >= 2; elaboration SHALL fail otherwise.
REQ-014 SHALL implement a state machine with states IDLE and SEND (plus CHK when REQ-027 applies).
REQ-015 In IDLE: s_ser_ready=1 and m_ser_valid=0; s_ser_valid=1 captures s_ser_data into a holding register, clears the beat index to 0, and moves to SEND.
REQ-016 In SEND: m_ser_valid=1 and m_ser_data = holding bits [(idx+1)*DATA_OUT_WIDTH-1 : idx*DATA_OUT_WIDTH], so beats go out least-significant beat first.
REQ-017 A beat transfers only when m_ser_valid and m_ser_ready are both 1; idx increments only on a transfer.
REQ-018 m_ser_data, m_ser_last and m_ser_valid SHALL stay stable while m_ser_valid=1 and m_ser_ready=0.
REQ-019 m_ser_last SHALL be 1 exactly on the final beat of a word (idx=NBEATS-1 without checksum).
REQ-020 s_ser_ready SHALL also be 1 in SEND during the cycle the final beat transfers.
  - If s_ser_valid=1 in that cycle, the new word loads, idx returns to 0 and the state stays SEND: no bubble cycle between words.
  - Otherwise the state returns to IDLE.
REQ-021 s_ser_ready SHALL be 0 in all other SEND cycles; s_ser_data is ignored then.
REQ-022 word_count SHALL increment by 1 in each cycle in which a final beat transfers.
REQ-023 First-beat latency: a word accepted in cycle N presents its first beat with m_ser_valid=1 in cycle N+1.
REQ-024 Sustained throughput SHALL be one beat per cycle while m_ser_ready=1 and words are available.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force:
  - state=IDLE, idx=0, holding register=0;
  - m_ser_valid=0, m_ser_last=0, m_ser_data=0;
  - word_count=0 and s_ser_ready=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word with no further beats; after release, s_ser_ready=1 from the first clock edge.

Configuration
REQ-027 With macro PDCCH_SER_CHECKSUM_EN defined:
  - after beat NBEATS-1 the state SHALL move to CHK and emit one extra beat equal to the XOR of all NBEATS data beats;
  - m_ser_last SHALL be 1 only on that checksum beat;
  - REQ-020 overlap and the word_count update SHALL apply to the checksum beat.
  Without the macro, no CHK state, no checksum logic, NBEATS beats per word.

Verification
REQ-028 Reset: hold reset=0 for 3 cycles -> m_ser_valid=0, word_count=0, s_ser_ready=0; after release s_ser_ready=1.
REQ-029 WORD_WIDTH=32, word 0xA1B2C3D4, m_ser_ready=1 -> beats D4,C3,B2,A1 on 4 consecutive cycles; last only on A1; word_count=1.
REQ-030 Back-to-back 0x11223344 then 0x55667788, both valid continuously -> 8 beats on 8 consecutive cycles with no gap; word_count=2.
REQ-031 Backpressure: m_ser_ready=0 for 5 cycles at beat C3 -> C3 held stable with valid=1, s_ser_ready=0; the sequence resumes without loss.
REQ-032 Reset pulse after beat C3 of 0xA1B2C3D4 -> no further beats; the next word 0x01020304 emits 04,03,02,01.
REQ-033 With PDCCH_SER_CHECKSUM_EN, word 0xA1B2C3D4 -> beats D4,C3,B2,A1,04; last only on 04.
